// File: rtl/seq_detector_p_if.sv
// Bundles the serial-side inputs and status outputs of the parametrised sequence detector.
// The master side drives sample data, pattern and mode. The slave side returns match, fill and count.
interface seq_detector_p_if #(
  parameter int N  = 8,
  parameter int CW = 8
);
  localparam int FW = $clog2(N + 1);

  logic          en;
  logic          ds;
  logic [N-1:0]  setd;
  logic          ovl;
  logic          dc;
  logic [FW-1:0] c;
  logic [CW-1:0] cnt;

  modport master (
    output en, ds, setd, ovl,
    input  dc, c, cnt
  );

  modport slave (
    input  en, ds, setd, ovl,
    output dc, c, cnt
  );
endinterface

// File: rtl/seq_detector_p.sv
// Serial sequence detector: compares the last N enabled samples of ds, MSB first, against setd.
// Supports overlapping and non-overlapping detection, a saturating match counter and a fill count.
module seq_detector_p #(
  parameter int N  = 8,
  parameter int CW = 8
) (
  input logic            clk,
  input logic            clr,
  seq_detector_p_if.slave bus
);
  localparam int            FW       = $clog2(N + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(N);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic [N-1:0]  hist;
  logic [FW-1:0] fill;
  logic [CW-1:0] cnt_q;
  logic          dc_q;

  logic [N-1:0]  h_next;
  logic [FW-1:0] f_next;
  logic          match;

  // setd and ovl are used live, so a pattern change applies from the next enabled sample.
  always_comb begin
    h_next = {hist[N-2:0], bus.ds};
    f_next = (fill == FILL_MAX) ? FILL_MAX : fill + 1'b1;
    match  = (f_next == FILL_MAX) && (h_next == bus.setd);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      hist  <= '0;
      fill  <= '0;
      cnt_q <= '0;
      dc_q  <= 1'b0;
    end else if (bus.en) begin
      hist <= h_next;
      dc_q <= match;
      // Non-overlap mode restarts the fill so the next match needs N fresh bits.
      if (match && !bus.ovl)
        fill <= '0;
      else
        fill <= f_next;
      if (match && (cnt_q != CNT_MAX))
        cnt_q <= cnt_q + 1'b1;
    end else begin
      dc_q <= 1'b0;
    end
  end

  assign bus.dc  = dc_q;
  assign bus.c   = fill;
  assign bus.cnt = cnt_q;
endmodule

// File: tb/tb_seq_detector_p.sv
// Directed self-checking bench for seq_detector_p using three parameterisations (N=4, N=8, N=2/CW=2).
module tb_seq_detector_p;
  logic clk;
  logic clr;
  int   total;
  int   passed;

  seq_detector_p_if #(.N(4), .CW(8)) i4 ();
  seq_detector_p_if #(.N(8), .CW(8)) i8 ();
  seq_detector_p_if #(.N(2), .CW(2)) i2 ();

  seq_detector_p #(.N(4), .CW(8)) u_d4 (.clk(clk), .clr(clr), .bus(i4.slave));
  seq_detector_p #(.N(8), .CW(8)) u_d8 (.clk(clk), .clr(clr), .bus(i8.slave));
  seq_detector_p #(.N(2), .CW(2)) u_d2 (.clk(clk), .clr(clr), .bus(i2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic s4(input logic e, input logic d, input logic x_dc, input int x_c,
                    input int x_cnt, input string tag);
    i4.en = e;
    i4.ds = d;
    tick();
    chk({tag, ".dc"}, 32'(i4.dc), 32'(x_dc));
    chk({tag, ".c"}, 32'(i4.c), 32'(x_c));
    chk({tag, ".cnt"}, 32'(i4.cnt), 32'(x_cnt));
  endtask

  task automatic s8(input logic d, input logic x_dc, input int x_c, input int x_cnt,
                    input string tag);
    i8.en = 1'b1;
    i8.ds = d;
    tick();
    chk({tag, ".dc"}, 32'(i8.dc), 32'(x_dc));
    chk({tag, ".c"}, 32'(i8.c), 32'(x_c));
    chk({tag, ".cnt"}, 32'(i8.cnt), 32'(x_cnt));
  endtask

  task automatic s2(input logic e, input logic d, input logic x_dc, input int x_c,
                    input int x_cnt, input string tag);
    i2.en = e;
    i2.ds = d;
    tick();
    chk({tag, ".dc"}, 32'(i2.dc), 32'(x_dc));
    chk({tag, ".c"}, 32'(i2.c), 32'(x_c));
    chk({tag, ".cnt"}, 32'(i2.cnt), 32'(x_cnt));
  endtask

  task automatic pulse_clr(input string tag);
    i4.en = 1'b0;
    i8.en = 1'b0;
    i2.en = 1'b0;
    clr   = 1'b1;
    tick();
    chk({tag, ".c4"}, 32'(i4.c), 32'd0);
    chk({tag, ".c8"}, 32'(i8.c), 32'd0);
    clr = 1'b0;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    clr    = 1'b1;
    i4.en = 1'b1; i4.ds = 1'b0; i4.setd = 4'b1011;   i4.ovl = 1'b1;
    i8.en = 1'b1; i8.ds = 1'b1; i8.setd = 8'hA5;     i8.ovl = 1'b1;
    i2.en = 1'b1; i2.ds = 1'b1; i2.setd = 2'b11;     i2.ovl = 1'b1;

    // Reset held for two cycles with en=1 and ds toggling.
    for (int k = 0; k < 2; k++) begin
      i4.ds = ~i4.ds;
      i8.ds = ~i8.ds;
      i2.ds = ~i2.ds;
      tick();
      chk("rst.dc4", 32'(i4.dc), 32'd0);
      chk("rst.c4", 32'(i4.c), 32'd0);
      chk("rst.cnt4", 32'(i4.cnt), 32'd0);
      chk("rst.c8", 32'(i8.c), 32'd0);
      chk("rst.dc2", 32'(i2.dc), 32'd0);
      chk("rst.cnt2", 32'(i2.cnt), 32'd0);
    end
    clr   = 1'b0;
    i8.en = 1'b0;
    i2.en = 1'b0;
    s4(1, 0, 0, 1, 0, "fill1");
    s4(1, 0, 0, 2, 0, "fill2");
    s4(1, 0, 0, 3, 0, "fill3");

    // Overlapping detection of 1011 in 1,0,1,1,0,1,1.
    pulse_clr("clr_ovl");
    i4.ovl = 1'b1;
    s4(1, 1, 0, 1, 0, "ovl1");
    s4(1, 0, 0, 2, 0, "ovl2");
    s4(1, 1, 0, 3, 0, "ovl3");
    s4(1, 1, 1, 4, 1, "ovl4");
    s4(1, 0, 0, 4, 1, "ovl5");
    s4(1, 1, 0, 4, 1, "ovl6");
    s4(1, 1, 1, 4, 2, "ovl7");

    // Non-overlapping: fill restarts after the match.
    pulse_clr("clr_novl");
    i4.ovl = 1'b0;
    s4(1, 1, 0, 1, 0, "novl1");
    s4(1, 0, 0, 2, 0, "novl2");
    s4(1, 1, 0, 3, 0, "novl3");
    s4(1, 1, 1, 0, 1, "novl4");
    s4(1, 0, 0, 1, 1, "novl5");
    s4(1, 1, 0, 2, 1, "novl6");
    s4(1, 1, 0, 3, 1, "novl7");

    // Enable gaps with garbage on ds while en=0.
    pulse_clr("clr_gap");
    i4.ovl = 1'b1;
    s4(1, 1, 0, 1, 0, "gap1");
    s4(0, 0, 0, 1, 0, "gap1x");
    s4(1, 0, 0, 2, 0, "gap2");
    s4(0, 1, 0, 2, 0, "gap2x");
    s4(1, 1, 0, 3, 0, "gap3");
    s4(0, 0, 0, 3, 0, "gap3x");
    s4(1, 1, 1, 4, 1, "gap4");
    s4(0, 0, 0, 4, 1, "gap4x");
    s4(0, 1, 0, 4, 1, "gap5x");

    // Mid-sequence reset on the 8-bit pattern A5.
    pulse_clr("clr_mid0");
    s8(1, 0, 1, 0, "pre1");
    s8(0, 0, 2, 0, "pre2");
    s8(1, 0, 3, 0, "pre3");
    s8(0, 0, 4, 0, "pre4");
    s8(0, 0, 5, 0, "pre5");
    pulse_clr("clr_mid");
    s8(1, 0, 1, 0, "post1");
    s8(0, 0, 2, 0, "post2");
    s8(1, 0, 3, 0, "post3");
    s8(0, 0, 4, 0, "post4");
    s8(0, 0, 5, 0, "post5");
    s8(1, 0, 6, 0, "post6");
    s8(0, 0, 7, 0, "post7");
    s8(1, 1, 8, 1, "post8");

    // Counter saturation with CW=2 on an all-ones pattern.
    pulse_clr("clr_sat");
    s2(1, 1, 0, 1, 0, "sat1");
    s2(1, 1, 1, 2, 1, "sat2");
    s2(1, 1, 1, 2, 2, "sat3");
    s2(1, 1, 1, 2, 3, "sat4");
    s2(1, 1, 1, 2, 3, "sat5");
    s2(1, 1, 1, 2, 3, "sat6");
    s2(0, 1, 0, 2, 3, "sat_idle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
